// File: rtl/mips_defines.sv
// Shared MIPS core definitions: divider state encodings and default iteration count.
package mips_defines;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// E-stage iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// result {remainder, quotient} feeds HI/LO, stall_o feeds the hazard unit.
module div_unit #(
  parameter int DIV_CYCLES = mips_defines::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  input  logic        stall_ext_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic [1:0]  state_dbg_o
);
  import mips_defines::*;

  localparam logic [5:0] LAST_COUNT = 6'(DIV_CYCLES - 1);

  div_state_t  state, state_nxt;
  logic [5:0]  count;
  logic [31:0] rem;
  logic [31:0] dq;
  logic [31:0] divisor;
  logic        sgn, dividend_neg, divisor_neg;

  logic [32:0] shifted, trial;
  logic        fits, last;
  logic [31:0] rem_step, dq_step;
  logic [31:0] abs_a, abs_b;
  logic [31:0] quo_fix, rem_fix;

  // Handshake: start_i is a level held by the pipeline while E is stalled;
  // ready_o marks result_o valid and stays up while stall_ext_i holds END.

  // One restoring step: dq shifts dividend bits out and quotient bits in.
  always_comb begin
    shifted  = {rem, dq[31]};
    trial    = shifted - {1'b0, divisor};
    fits     = ~trial[32];
    rem_step = fits ? trial[31:0] : shifted[31:0];
    dq_step  = {dq[30:0], fits};
    last     = (count == LAST_COUNT);
    abs_a    = (signed_i & opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    abs_b    = (signed_i & opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    quo_fix  = (sgn & (dividend_neg ^ divisor_neg)) ? (~dq_step + 32'd1) : dq_step;
    rem_fix  = (sgn & dividend_neg) ? (~rem_step + 32'd1) : rem_step;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_FREE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (annul_i) begin
      state_nxt = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE:    if (start_i) state_nxt = (opdata2_i == 32'd0) ? DIV_BY_ZERO : DIV_ON;
        DIV_BY_ZERO: state_nxt = DIV_END;
        DIV_ON:      if (last) state_nxt = DIV_END;
        DIV_END:     if (!stall_ext_i) state_nxt = DIV_FREE;
        default:     state_nxt = DIV_FREE;
      endcase
    end
  end

  always_comb begin
    ready_o     = (state == DIV_END);
    stall_o     = start_i & ~annul_i & (state != DIV_END);
    state_dbg_o = state;
  end

  // Operands are stored as magnitudes; the signs are kept for the fix-up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      rem          <= '0;
      dq           <= '0;
      divisor      <= '0;
      sgn          <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      result_o     <= '0;
    end else if (annul_i) begin
      count    <= '0;
      result_o <= '0;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i) begin
            sgn          <= signed_i;
            dividend_neg <= opdata1_i[31];
            divisor_neg  <= opdata2_i[31];
            dq           <= abs_a;
            divisor      <= abs_b;
            rem          <= '0;
            count        <= '0;
            result_o     <= '0;
          end
        end
        DIV_ON: begin
          rem <= rem_step;
          dq  <= dq_step;
          if (last) result_o <= {rem_fix, quo_fix};
          else      count    <= count + 6'd1;
        end
        DIV_BY_ZERO: result_o <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed plus randomized bench for div_unit against an arithmetic reference model.
module tb_div_unit;
  import mips_defines::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, signed_i, annul_i, stall_ext_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stall_o;
  logic [1:0]  state_dbg_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_unit #(.DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .stall_ext_i(stall_ext_i), .result_o(result_o), .ready_o(ready_o),
    .stall_o(stall_o), .state_dbg_o(state_dbg_o)
  );

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one division; cycle 0 is the cycle start_i is first seen in FREE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int hold, input int drop_at, input bit from_reset);
    int lat_exp;
    int cyc;
    int got;
    bit stall_ok;
    logic [63:0] res;
    lat_exp  = (b == 32'd0) ? 2 : 33;
    cyc      = 0;
    got      = -1;
    stall_ok = 1'b1;
    exp_q.push_back(ref_div(a, b, sgn));
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    if (from_reset) begin #1 resetn = 1'b1; end
    while (cyc < 60) begin
      if (cyc == drop_at) start_i = 1'b0;
      @(negedge clk);
      if (stall_o !== (start_i & (cyc < lat_exp))) stall_ok = 1'b0;
      if (ready_o === 1'b1) begin
        got = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("stall_window", 64'(stall_ok), 64'd1);
    check("ready_latency", 64'(got), 64'(lat_exp));
    check("result", result_o, exp_q.pop_front());
    res = result_o;
    start_i = 1'b0;
    stall_ext_i = (hold > 0);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      if (k == hold) stall_ext_i = 1'b0;
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, res);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("back_to_free", 64'({ready_o, state_dbg_o}), 64'({1'b0, DIV_FREE}));
  endtask

  initial begin
    int pulses;
    int sel;
    logic [31:0] a, b;
    resetn = 1'b0; start_i = 1'b1; signed_i = 1'b0; annul_i = 1'b0;
    stall_ext_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_state", 64'(state_dbg_o), 64'(DIV_FREE));
    check("rst_stall", 64'(stall_o), 64'd1);
    annul_i = 1'b1; #1;
    check("rst_stall_annul", 64'(stall_o), 64'd0);
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 0, -1, 1'b0);
    check("divu_100_7_const", result_o, 64'h00000002_0000000E);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 0, -1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, -1, 1'b0);
    check("div_overflow_const", result_o, 64'h00000000_80000000);
    do_div(32'd5, 32'd0, 1'b0, 0, -1, 1'b0);
    do_div(32'd1000, 32'd33, 1'b0, 3, -1, 1'b0);
    do_div(32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, 0, 5, 1'b0);

    // Annul in the middle of ON
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = $urandom; opdata2_i = $urandom_range(1, 1000);
    for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("annul_state", 64'({ready_o, state_dbg_o}), 64'({1'b0, DIV_FREE}));
    check("annul_result", result_o, 64'd0);
    do_div($urandom, $urandom_range(1, 100), 1'b0, 0, -1, 1'b0);

    // Annul and start together in FREE: nothing starts
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1; opdata2_i = 32'd3;
    @(negedge clk);
    check("annul_start_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);
    check("annul_start_free", 64'(state_dbg_o), 64'(DIV_FREE));

    // Reset in the middle of ON
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = $urandom; opdata2_i = $urandom_range(1, 50);
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
    resetn = 1'b0; #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_state", 64'(state_dbg_o), 64'(DIV_FREE));
    check("midrst_stall", 64'(stall_o), 64'd1);
    start_i = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) pulses++;
    end
    check("midrst_no_ready", 64'(pulses), 64'd0);

    // Start held across reset release
    resetn = 1'b0;
    @(posedge clk); #1;
    do_div(32'd12345, 32'd67, 1'b0, 0, -1, 1'b1);

    // Randomized operands
    for (int n = 0; n < 20; n++) begin
      sel = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case (sel)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'd0;
        default: b = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
